vector_alu_dispatch: RTL and testbench
======================================

VECTOR_ALU_DISPATCH -- requirements
Module: vector_alu_dispatch

Interface
REQ-001 The block SHALL expose parameter LANES, default 4, meaning the number of ALU lanes driven per issued beat.
REQ-002 The block SHALL expose parameter VLEN, default 8, meaning the number of vector elements per VR instruction.
REQ-003 The block SHALL expose parameter MUL_LAT, default 2, meaning the cycles from operation start to out_valid for mul.
REQ-004 The block SHALL expose parameter DIV_LAT, default 8, meaning the cycles from operation start to out_valid for div and mod.
REQ-005 The block SHALL have one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  clock; all state updates on the rising edge.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 in_valid  input  1  instruction class and funct fields are valid.
REQ-009 in_ready  output  1  the block can accept an instruction.
REQ-010 R, I, U, VR, abs  input  1 each  instruction-class flags.
REQ-011 funct3  input  3  raw funct3 field.
REQ-012 funct7  input  7  raw funct7 field.
REQ-013 out_valid  output  1  the beat payload is valid.
REQ-014 out_ready  input  1  the downstream execute stage accepts the beat.
REQ-015 alu_op  output  4  the ALU operation code.
REQ-016 lane_base  output  clog2(VLEN) (minimum 1)  the element index of lane 0 for this beat.
REQ-017 lane_mask  output  LANES  per-lane enable.
REQ-018 last  output  1  this is the final beat of the instruction.
REQ-019 illegal  output  1  the funct3/funct7 combination is unsupported.
REQ-020 busy  output  1  an instruction is in flight.

Function
REQ-021 Op codes SHALL be: add 0, sub 1, xor 2, or 3, and 4, sll 5, srl 6, sra 7, slt 8, sltu 9, passB 11, passA 12, mul 13, div 14, mod 15; code 10 is never produced.
REQ-022 Decode priority SHALL be abs (passA), then U (passB), then R/VR, then I; with no flag set, the block SHALL produce add.
REQ-023 Decoding of R/VR SHALL use these mappings; any other R/VR combination SHALL give add with illegal=1.
- funct7=0x00: f3 0..7 map to add, sll, slt, sltu, xor, srl, or, and.
- funct7=0x20: f3=0 gives sub and f3=5 gives sra.
- funct7=0x01: f3=0 gives mul, f3=4 gives div and f3=6 gives mod.
REQ-024 Decoding of I SHALL use funct3 alone, except that f3=5 SHALL give sra when funct7=0x20, srl when funct7=0x00, and illegal otherwise; I f3=0 SHALL give add (no sub).
REQ-025 The FSM SHALL have three states: IDLE, WAIT and ISSUE. in_ready SHALL be 1 only in IDLE and not in reset.
REQ-026 On in_valid && in_ready, the block SHALL register the decoded op, clear lane_base to 0 and set busy=1.
- Single-cycle ops SHALL go to ISSUE.
- mul SHALL go to WAIT with a counter of MUL_LAT-1.
- div and mod SHALL go to WAIT with a counter of DIV_LAT-1.
REQ-027 WAIT SHALL decrement the counter each cycle and move to ISSUE in the cycle after the counter reaches 0.
- out_valid SHALL rise exactly MUL_LAT or DIV_LAT cycles after acceptance.
- For single-cycle ops, out_valid SHALL rise 1 cycle after acceptance.
REQ-028 In ISSUE, out_valid SHALL be 1, and alu_op, lane_base, lane_mask, last and illegal SHALL hold stable until out_ready=1.
REQ-029 Beat count SHALL be 1 for non-VR instructions and ceil(VLEN/LANES) for VR instructions.
REQ-030 lane_mask[i] SHALL be (lane_base+i < VLEN) for VR, giving a partial final beat.
REQ-031 lane_mask SHALL be 1 (lane 0 only) for non-VR instructions.
REQ-032 last SHALL be 1 on the final beat only.
REQ-033 On an out_valid && out_ready handshake with last=1, the FSM SHALL go to IDLE and clear busy.
REQ-034 On a handshake with last=0, lane_base SHALL advance by LANES. Single-cycle ops SHALL re-enter ISSUE (back-to-back beats); multicycle ops SHALL re-enter WAIT with the counter reloaded.
REQ-035 in_valid outside IDLE SHALL be ignored, with no state change.
REQ-036 illegal instructions SHALL issue exactly one beat with lane_mask=1, even when VR=1.
REQ-037 MUL_LAT and DIV_LAT equal to 1 SHALL skip WAIT (behaves as single-cycle).
REQ-038 LANES >= VLEN SHALL give a single VR beat.
REQ-039 The beat counter and lane_base SHALL not wrap; no beat with lane_base >= VLEN SHALL be issued.

Reset
REQ-040 While rst=1, the outputs SHALL be: out_valid=0, busy=0, last=0, illegal=0, alu_op=0, lane_base=0, lane_mask=0 and in_ready=0; the FSM SHALL enter IDLE.
REQ-041 Reset mid-instruction SHALL abandon it, with no further beats.
REQ-042 in_ready SHALL be 1 in the first cycle after rst falls.

Verification
REQ-043 The bench SHALL check that R, f3=0, f7=0x20, out_ready=1 -> alu_op=1, out_valid 1 cycle after accept, last=1, lane_mask=0001, in_ready back to 1 the following cycle.
REQ-044 The bench SHALL check that VR, f3=4, f7=0x01, LANES=4, VLEN=10, DIV_LAT=8 -> three beats of alu_op=14 with lane_base 0/4/8, lane_mask 1111/1111/0011, each out_valid 8 cycles after accept or the previous handshake, last on the third beat only.
REQ-045 The bench SHALL check that VR add with out_ready held 0 for 5 cycles on beat 1 -> payload stable, no beat skipped, then beat 2 in the cycle after the handshake.
REQ-046 The bench SHALL check that abs=1 and U=1 with R, f3=0, f7=0x01 -> alu_op=12, single beat, illegal=0.
REQ-047 The bench SHALL check that R, f3=1, f7=0x20 -> alu_op=0, illegal=1; a VR illegal gives one beat only.
REQ-048 The bench SHALL check that rst pulsed during WAIT of a mul -> no out_valid afterwards, busy=0, and a new I f3=5, f7=0x20 instruction gives alu_op=7.

Source files
------------

// File: rtl/vector_alu_dispatch.sv
// Vector ALU dispatch: decodes RISC-V style class/funct fields into an ALU op and issues
// one or more lane-masked beats per instruction, padding mul/div with fixed latency waits.
module vector_alu_dispatch #(
    parameter int unsigned LANES   = 4,
    parameter int unsigned VLEN    = 8,
    parameter int unsigned MUL_LAT = 2,
    parameter int unsigned DIV_LAT = 8,
    localparam int unsigned LBW    = (VLEN > 1) ? $clog2(VLEN) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             R,
    input  logic             I,
    input  logic             U,
    input  logic             VR,
    input  logic             abs,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       alu_op,
    output logic [LBW-1:0]   lane_base,
    output logic [LANES-1:0] lane_mask,
    output logic             last,
    output logic             illegal,
    output logic             busy
);

    localparam int unsigned MaxLat = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int unsigned CW     = (MaxLat > 1) ? $clog2(MaxLat) : 1;

    localparam logic [3:0] OpAdd   = 4'd0;
    localparam logic [3:0] OpSub   = 4'd1;
    localparam logic [3:0] OpXor   = 4'd2;
    localparam logic [3:0] OpOr    = 4'd3;
    localparam logic [3:0] OpAnd   = 4'd4;
    localparam logic [3:0] OpSll   = 4'd5;
    localparam logic [3:0] OpSrl   = 4'd6;
    localparam logic [3:0] OpSra   = 4'd7;
    localparam logic [3:0] OpSlt   = 4'd8;
    localparam logic [3:0] OpSltu  = 4'd9;
    localparam logic [3:0] OpPassB = 4'd11;
    localparam logic [3:0] OpPassA = 4'd12;
    localparam logic [3:0] OpMul   = 4'd13;
    localparam logic [3:0] OpDiv   = 4'd14;
    localparam logic [3:0] OpMod   = 4'd15;

    typedef enum logic [1:0] {StIdle, StWait, StIssue} state_e;

    state_e          state_q, state_d;
    logic [3:0]      op_q, op_d;
    logic            ill_q, ill_d;
    logic            vec_q, vec_d;
    logic            multi_q, multi_d;
    logic [CW-1:0]   reload_q, reload_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [LBW-1:0]  base_q, base_d;

    logic [3:0]      dec_op;
    logic            dec_ill;
    int unsigned     dec_lat;
    logic [31:0]     base_ext;
    logic [31:0]     next_base;
    logic            beat_last;
    logic [LANES-1:0] mask_raw;
    logic            accept;

    // Instruction decode, priority abs > U > R/VR > I.
    always_comb begin
        dec_op  = OpAdd;
        dec_ill = 1'b0;
        if (abs) begin
            dec_op = OpPassA;
        end else if (U) begin
            dec_op = OpPassB;
        end else if (R || VR) begin
            case (funct7)
                7'h00: begin
                    unique case (funct3)
                        3'd0: dec_op = OpAdd;
                        3'd1: dec_op = OpSll;
                        3'd2: dec_op = OpSlt;
                        3'd3: dec_op = OpSltu;
                        3'd4: dec_op = OpXor;
                        3'd5: dec_op = OpSrl;
                        3'd6: dec_op = OpOr;
                        3'd7: dec_op = OpAnd;
                    endcase
                end
                7'h20: begin
                    if (funct3 == 3'd0) begin
                        dec_op = OpSub;
                    end else if (funct3 == 3'd5) begin
                        dec_op = OpSra;
                    end else begin
                        dec_ill = 1'b1;
                    end
                end
                7'h01: begin
                    if (funct3 == 3'd0) begin
                        dec_op = OpMul;
                    end else if (funct3 == 3'd4) begin
                        dec_op = OpDiv;
                    end else if (funct3 == 3'd6) begin
                        dec_op = OpMod;
                    end else begin
                        dec_ill = 1'b1;
                    end
                end
                default: dec_ill = 1'b1;
            endcase
        end else if (I) begin
            unique case (funct3)
                3'd0: dec_op = OpAdd;
                3'd1: dec_op = OpSll;
                3'd2: dec_op = OpSlt;
                3'd3: dec_op = OpSltu;
                3'd4: dec_op = OpXor;
                3'd5: begin
                    if (funct7 == 7'h20) begin
                        dec_op = OpSra;
                    end else if (funct7 == 7'h00) begin
                        dec_op = OpSrl;
                    end else begin
                        dec_ill = 1'b1;
                    end
                end
                3'd6: dec_op = OpOr;
                3'd7: dec_op = OpAnd;
            endcase
        end
    end

    always_comb begin
        dec_lat = 1;
        if (dec_op == OpMul) begin
            dec_lat = MUL_LAT;
        end else if (dec_op == OpDiv || dec_op == OpMod) begin
            dec_lat = DIV_LAT;
        end
    end

    // Beat geometry; the last test is done in 32 bits so lane_base never needs to wrap.
    always_comb begin
        base_ext  = 32'(base_q);
        next_base = base_ext + LANES;
        beat_last = !vec_q || (next_base >= VLEN);
        mask_raw  = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (vec_q) begin
                mask_raw[i] = (base_ext + 32'(i)) < VLEN;
            end else begin
                mask_raw[i] = (i == 0);
            end
        end
    end

    assign accept = in_valid && in_ready;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        ill_d    = ill_q;
        vec_d    = vec_q;
        multi_d  = multi_q;
        reload_d = reload_q;
        cnt_d    = cnt_q;
        base_d   = base_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    op_d     = dec_op;
                    ill_d    = dec_ill;
                    vec_d    = VR && !dec_ill;
                    multi_d  = dec_lat > 1;
                    reload_d = CW'(dec_lat - 1);
                    cnt_d    = CW'(dec_lat - 1);
                    base_d   = '0;
                    state_d  = (dec_lat > 1) ? StWait : StIssue;
                end
            end
            StWait: begin
                if (cnt_q <= CW'(1)) begin
                    state_d = StIssue;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            StIssue: begin
                if (out_ready) begin
                    if (beat_last) begin
                        state_d = StIdle;
                    end else begin
                        base_d = LBW'(next_base);
                        if (multi_q) begin
                            cnt_d   = reload_q;
                            state_d = StWait;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            op_q     <= 4'd0;
            ill_q    <= 1'b0;
            vec_q    <= 1'b0;
            multi_q  <= 1'b0;
            reload_q <= '0;
            cnt_q    <= '0;
            base_q   <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            ill_q    <= ill_d;
            vec_q    <= vec_d;
            multi_q  <= multi_d;
            reload_q <= reload_d;
            cnt_q    <= cnt_d;
            base_q   <= base_d;
        end
    end

    // Outputs are forced to zero combinationally while reset is held.
    always_comb begin
        in_ready  = (state_q == StIdle) && !rst;
        out_valid = (state_q == StIssue) && !rst;
        busy      = (state_q != StIdle) && !rst;
        last      = out_valid && beat_last;
        illegal   = !rst && ill_q;
        alu_op    = rst ? 4'd0 : op_q;
        lane_base = rst ? '0 : base_q;
        lane_mask = rst ? '0 : mask_raw;
    end

endmodule

// File: tb/tb_vector_alu_dispatch.sv
// Scoreboard bench for vector_alu_dispatch: directed instructions push expected beats,
// a negedge monitor checks payload, stability under stall and per-beat latency.
module tb_vector_alu_dispatch;

    localparam int unsigned LANES   = 4;
    localparam int unsigned VLEN    = 10;
    localparam int unsigned MUL_LAT = 2;
    localparam int unsigned DIV_LAT = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       R, I, U, VR, ab;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] alu_op;
    logic [3:0] lane_base;
    logic [3:0] lane_mask;
    logic       last;
    logic       illegal;
    logic       busy;

    always #5 clk = ~clk;

    vector_alu_dispatch #(
        .LANES  (LANES),
        .VLEN   (VLEN),
        .MUL_LAT(MUL_LAT),
        .DIV_LAT(DIV_LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .R        (R),
        .I        (I),
        .U        (U),
        .VR       (VR),
        .abs      (ab),
        .funct3   (funct3),
        .funct7   (funct7),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .alu_op   (alu_op),
        .lane_base(lane_base),
        .lane_mask(lane_mask),
        .last     (last),
        .illegal  (illegal),
        .busy     (busy)
    );

    typedef struct packed {
        logic [3:0] op;
        logic [3:0] base;
        logic [3:0] mask;
        logic       lst;
        logic       ill;
        logic [7:0] dly;
    } beat_t;

    beat_t sb[$];
    int    checks   = 0;
    int    errors   = 0;
    int    cyc      = 0;
    int    last_evt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    task automatic push(input logic [3:0] op, input logic [3:0] base, input logic [3:0] mask,
                        input logic lst, input logic ill, input int dly);
        beat_t b;
        b.op = op; b.base = base; b.mask = mask; b.lst = lst; b.ill = ill; b.dly = 8'(dly);
        sb.push_back(b);
    endtask

    // Flags packed as {R, I, U, VR, abs}.
    task automatic issue(input logic [4:0] flags, input logic [2:0] f3, input logic [6:0] f7);
        int n = 0;
        while (!in_ready && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 300) chk("issue_timeout", 32'(in_ready), 32'd1);
        {R, I, U, VR, ab} = flags;
        funct3   = f3;
        funct7   = f7;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((busy || sb.size() != 0) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 300) chk("drain_timeout", 32'(sb.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: payload compared every valid cycle (stall stability), latency on handshake.
    initial forever begin
        beat_t e;
        @(negedge clk);
        if (in_valid && in_ready) last_evt = cyc;
        if (out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_beat", 32'(out_valid), 32'd0);
            end else begin
                e = sb[0];
                chk("alu_op", 32'(alu_op), 32'(e.op));
                chk("lane_base", 32'(lane_base), 32'(e.base));
                chk("lane_mask", 32'(lane_mask), 32'(e.mask));
                chk("last", 32'(last), 32'(e.lst));
                chk("illegal", 32'(illegal), 32'(e.ill));
                if (out_ready) begin
                    chk("latency", 32'(cyc - last_evt), 32'(e.dly));
                    void'(sb.pop_front());
                    last_evt = cyc;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        {R, I, U, VR, ab} = 5'b0; funct3 = 3'd0; funct7 = 7'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_last", 32'(last), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_lane_base", 32'(lane_base), 32'd0);
        chk("rst_lane_mask", 32'(lane_mask), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", 32'(in_ready), 32'd1);

        // R sub, single beat, ready again the cycle after the handshake.
        push(4'd1, 4'd0, 4'b0001, 1'b1, 1'b0, 1);
        issue(5'b10000, 3'd0, 7'h20);
        @(posedge clk); #1;
        chk("sub_in_ready_back", 32'(in_ready), 32'd1);
        chk("sub_busy_clear", 32'(busy), 32'd0);

        // VR div: three beats, eight cycles apart; in_valid while busy is ignored.
        push(4'd14, 4'd0, 4'b1111, 1'b0, 1'b0, 8);
        push(4'd14, 4'd4, 4'b1111, 1'b0, 1'b0, 8);
        push(4'd14, 4'd8, 4'b0011, 1'b1, 1'b0, 8);
        issue(5'b00010, 3'd4, 7'h01);
        {R, I, U, VR, ab} = 5'b00100;
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("busy_in_wait", 32'(busy), 32'd1);
        in_valid = 1'b0;
        wait_done();

        // VR add with a 5-cycle stall on beat 1.
        out_ready = 1'b0;
        push(4'd0, 4'd0, 4'b1111, 1'b0, 1'b0, 6);
        push(4'd0, 4'd4, 4'b1111, 1'b0, 1'b0, 1);
        push(4'd0, 4'd8, 4'b0011, 1'b1, 1'b0, 1);
        issue(5'b00010, 3'd0, 7'h00);
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_done();

        // abs beats U and a mul encoding.
        push(4'd12, 4'd0, 4'b0001, 1'b1, 1'b0, 1);
        issue(5'b10101, 3'd0, 7'h01);
        wait_done();

        // Illegal R, then illegal VR gives one beat only.
        push(4'd0, 4'd0, 4'b0001, 1'b1, 1'b1, 1);
        issue(5'b10000, 3'd1, 7'h20);
        wait_done();
        push(4'd0, 4'd0, 4'b0001, 1'b1, 1'b1, 1);
        issue(5'b00010, 3'd1, 7'h20);
        wait_done();

        // Assorted decodes.
        push(4'd13, 4'd0, 4'b0001, 1'b1, 1'b0, 2);   // R mul
        issue(5'b10000, 3'd0, 7'h01);
        wait_done();
        push(4'd6, 4'd0, 4'b0001, 1'b1, 1'b0, 1);    // I srl
        issue(5'b01000, 3'd5, 7'h00);
        wait_done();
        push(4'd0, 4'd0, 4'b0001, 1'b1, 1'b1, 1);    // I f3=5 bad funct7
        issue(5'b01000, 3'd5, 7'h01);
        wait_done();
        push(4'd0, 4'd0, 4'b0001, 1'b1, 1'b0, 1);    // I f3=0 never sub
        issue(5'b01000, 3'd0, 7'h20);
        wait_done();
        push(4'd11, 4'd0, 4'b0001, 1'b1, 1'b0, 1);   // U passB
        issue(5'b00100, 3'd3, 7'h00);
        wait_done();
        push(4'd8, 4'd0, 4'b0001, 1'b1, 1'b0, 1);    // R slt
        issue(5'b10000, 3'd2, 7'h00);
        wait_done();
        push(4'd0, 4'd0, 4'b0001, 1'b1, 1'b0, 1);    // no flags
        issue(5'b00000, 3'd7, 7'h01);
        wait_done();
        push(4'd15, 4'd0, 4'b1111, 1'b0, 1'b0, 8);   // VR mod
        push(4'd15, 4'd4, 4'b1111, 1'b0, 1'b0, 8);
        push(4'd15, 4'd8, 4'b0011, 1'b1, 1'b0, 8);
        issue(5'b00010, 3'd6, 7'h01);
        wait_done();

        // Reset during a mul WAIT abandons it.
        issue(5'b10000, 3'd0, 7'h01);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("postrst_out_valid", 32'(out_valid), 32'd0);
            chk("postrst_busy", 32'(busy), 32'd0);
            @(posedge clk); #1;
        end
        push(4'd7, 4'd0, 4'b0001, 1'b1, 1'b0, 1);    // I sra
        issue(5'b01000, 3'd5, 7'h20);
        wait_done();

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
